// File: rtl/pdt_update_ctrl_pkg.sv
// pdt_defs: shared constants, counter/state encodings and update-queue entry layout for the PHT update path
package pdt_defs;
  localparam int HIST_W = 12;
  localparam int PHT_DEPTH = 4096;
  localparam logic [1:0] SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11;
  typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_e;
  typedef struct packed {
    logic [HIST_W-1:0] idx;
    logic              taken;
  } upd_t;
  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic taken);
    return taken ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/pdt_upd_fifo.sv
// pdt_upd_fifo: synchronous FIFO; a push while full is honoured only alongside a pop
module pdt_upd_fifo #(
  parameter int W = 13,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rp_q];
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | pop_i);
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(do_push);
      rp_q <= rp_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/pdt_update_ctrl.sv
// pdt_update_ctrl: sweeps the gshare PHT after reset, then serializes resolved-branch counter updates
module pdt_update_ctrl #(
  parameter int HIST_W = pdt_defs::HIST_W,
  parameter int PHT_DEPTH = pdt_defs::PHT_DEPTH,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_next_pc,
  input  logic [ADDR_W-1:0] ex_pdt_pc,
  output logic [HIST_W-1:0] ghr,
  output logic              pht_rd_en,
  output logic [HIST_W-1:0] pht_rd_idx,
  input  logic [1:0]        pht_rdata,
  output logic              pht_we,
  output logic [HIST_W-1:0] pht_widx,
  output logic [1:0]        pht_wdata,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              stallreq,
  output logic              init_busy
);
  import pdt_defs::*;
  localparam int EW = HIST_W + 1;
  state_e state_q, state_d;
  logic [HIST_W-1:0] cnt_q, ghr_q, widx_q, ridx_q, widx_d;
  logic [EW-1:0] work_q, head;
  logic [1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] redir_q;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic flush_q, full, empty, pop, acc, we, rd_en, unused_ok;
  assign init_busy = rst | (state_q == INIT);
  assign stallreq = init_busy | full;
  assign acc = ex_valid & ~stallreq;
  assign pop = (state_q == IDLE) & ~empty;
  assign unused_ok = ^{ex_pc[ADDR_W-1:HIST_W+2], ex_pc[1:0], fifo_cnt};
  pdt_upd_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(acc), .pop_i(pop),
    .wdata_i({ex_pc[HIST_W+1:2] ^ ghr_q, ex_taken}), .rdata_o(head),
    .full_o(full), .empty_o(empty), .count_o(fifo_cnt)
  );
  always_comb begin
    state_d = state_q;
    we = 1'b0;
    rd_en = 1'b0;
    widx_d = widx_q;
    wdata_d = wdata_q;
    case (state_q)
      INIT: begin
        we = 1'b1;
        widx_d = cnt_q;
        wdata_d = SNT;
        state_d = cnt_q == HIST_W'(PHT_DEPTH - 1) ? IDLE : INIT;
      end
      IDLE: state_d = empty ? IDLE : READ;
      READ: begin
        rd_en = 1'b1;
        state_d = WRITE;
      end
      default: begin
        we = 1'b1;
        widx_d = work_q[EW-1:1];
        wdata_d = sat_upd(pht_rdata, work_q[0]);
        state_d = IDLE;
      end
    endcase
  end
  // Write/read strobes and the flush pulse are held quiet for as long as reset is asserted
  assign pht_we = we & ~rst;
  assign pht_widx = rst ? '0 : widx_d;
  assign pht_wdata = rst ? '0 : wdata_d;
  assign pht_rd_en = rd_en & ~rst;
  assign pht_rd_idx = rd_en ? work_q[EW-1:1] : ridx_q;
  assign flush = flush_q & ~rst;
  assign redirect_pc = rst ? '0 : redir_q;
  assign ghr = ghr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      ghr_q <= '0;
      flush_q <= 1'b0;
      redir_q <= '0;
      widx_q <= '0;
      wdata_q <= '0;
      ridx_q <= '0;
      work_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_q + HIST_W'(state_q == INIT);
      ghr_q <= acc ? {ghr_q[HIST_W-2:0], ex_taken} : ghr_q;
      flush_q <= acc & (ex_next_pc != ex_pdt_pc);
      redir_q <= acc ? ex_next_pc : redir_q;
      widx_q <= widx_d;
      wdata_q <= wdata_d;
      ridx_q <= pht_rd_idx;
      work_q <= pop ? head : work_q;
    end
  end
endmodule

// File: tb/tb_pdt_update_ctrl.sv
// tb_pdt_update_ctrl: directed vectors plus randomized traffic against a queue-level reference model
module tb_pdt_update_ctrl;
  logic clk = 0, rst = 1, ex_valid = 0, ex_taken = 0;
  logic [31:0] ex_pc = 0, ex_next_pc = 0, ex_pdt_pc = 0, redirect_pc;
  logic [11:0] ghr, pht_rd_idx, pht_widx;
  logic pht_rd_en, pht_we, flush, stallreq, init_busy;
  logic [1:0] pht_rdata, pht_wdata;
  logic pre_en = 0;
  logic [11:0] pre_idx = 0;
  logic [1:0] pre_val = 0;
  logic [1:0] mem [4096];
  int checks = 0, failures = 0;

  logic [11:0] ghr_m;
  logic [1:0] pht_m [4096];
  logic [13:0] wq [$];
  int fifo_n, eng;
  bit exp_flush;
  logic [31:0] exp_redir;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [1:0]  pre;
    logic [11:0] idx;
    logic [1:0]  w;
    logic [11:0] ghr;
  } vec_t;
  vec_t vt [6];

  pdt_update_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_next_pc(ex_next_pc), .ex_pdt_pc(ex_pdt_pc), .ghr(ghr), .pht_rd_en(pht_rd_en),
    .pht_rd_idx(pht_rd_idx), .pht_rdata(pht_rdata), .pht_we(pht_we), .pht_widx(pht_widx),
    .pht_wdata(pht_wdata), .flush(flush), .redirect_pc(redirect_pc), .stallreq(stallreq),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // PHT storage with a synchronous read port
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    if (pht_we) mem[pht_widx] <= pht_wdata;
    if (pht_rd_en) pht_rdata <= mem[pht_rd_idx];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] idx, input logic [1:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_en = 1;
    tick;
    pre_en = 0;
  endtask

  task automatic check_sweep(input string tag);
    int bad = 0;
    for (int i = 0; i < 4096; i++) begin
      if ({init_busy, stallreq, pht_we} !== 3'b111 || pht_widx !== 12'(i) || pht_wdata !== 2'b00) bad++;
      tick;
    end
    chk({tag, "_bad_cycles"}, bad, 0);
    chk({tag, "_init_busy_done"}, init_busy, 0);
    chk({tag, "_stallreq_done"}, stallreq, 0);
    chk({tag, "_ghr_done"}, ghr, 0);
    chk({tag, "_we_done"}, pht_we, 0);
  endtask

  task automatic run_model(input int n, input int mode);
    bit v, t, acc, pop;
    logic [31:0] pc, np, pdt;
    logic [11:0] idx;
    logic [13:0] e;
    int c;
    for (int k = 0; k < n; k++) begin
      chk("stallreq", stallreq, fifo_n == 4);
      chk("ghr", ghr, ghr_m);
      chk("flush", flush, exp_flush);
      if (exp_flush) chk("redirect_pc", redirect_pc, exp_redir);
      chk("pht_rd_en", pht_rd_en, eng == 1);
      chk("pht_we", pht_we, eng == 2);
      if (eng == 2) begin
        e = wq.pop_front();
        chk("pht_widx", pht_widx, e[13:2]);
        chk("pht_wdata", pht_wdata, e[1:0]);
      end
      v = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      pc = $urandom;
      t = 1'($urandom_range(0, 1));
      np = $urandom;
      pdt = $urandom_range(0, 3) == 0 ? $urandom : np;
      ex_valid = v; ex_pc = pc; ex_taken = t; ex_next_pc = np; ex_pdt_pc = pdt;
      acc = v && fifo_n != 4;
      pop = eng == 0 && fifo_n > 0;
      eng = pop ? 1 : eng == 1 ? 2 : 0;
      fifo_n = fifo_n + int'(acc) - int'(pop);
      if (acc) begin
        idx = pc[13:2] ^ ghr_m;
        c = int'(pht_m[idx]);
        c = t ? (c == 3 ? 3 : c + 1) : (c == 0 ? 0 : c - 1);
        pht_m[idx] = 2'(c);
        wq.push_back({idx, 2'(c)});
        ghr_m = {ghr_m[10:0], t};
      end
      exp_flush = acc && np != pdt;
      exp_redir = np;
      tick;
    end
    ex_valid = 0;
  endtask

  initial begin
    int wcnt;
    vt[0] = '{32'h0000_0040, 1'b1, 2'd1, 12'h010, 2'd2, 12'h001};
    vt[1] = '{32'h0000_0040, 1'b1, 2'd3, 12'h011, 2'd3, 12'h003};
    vt[2] = '{32'h0000_0080, 1'b0, 2'd0, 12'h023, 2'd0, 12'h006};
    vt[3] = '{32'h0000_1234, 1'b0, 2'd2, 12'h48B, 2'd1, 12'h00C};
    vt[4] = '{32'hFFFF_FFFC, 1'b1, 2'd2, 12'hFF3, 2'd3, 12'h019};
    vt[5] = '{32'h0000_3FFC, 1'b0, 2'd1, 12'hFE6, 2'd0, 12'h032};
    for (int i = 0; i < 4096; i++) pht_m[i] = 2'd0;

    tick; tick;
    chk("rst_pht_we", pht_we, 0);
    chk("rst_rd_en", pht_rd_en, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_widx", pht_widx, 0);
    chk("rst_wdata", pht_wdata, 0);
    chk("rst_stallreq", stallreq, 1);
    chk("rst_init_busy", init_busy, 1);
    rst = 0;
    #1;
    check_sweep("sweep1");

    foreach (vt[i]) begin
      preload(vt[i].idx, vt[i].pre);
      ex_valid = 1; ex_pc = vt[i].pc; ex_taken = vt[i].taken;
      ex_next_pc = 32'h80; ex_pdt_pc = 32'h80;
      tick;
      ex_valid = 0;
      chk("vec_ghr", ghr, vt[i].ghr);
      chk("vec_flush", flush, 0);
      chk("vec_pop_we", pht_we, 0);
      tick;
      chk("vec_rd_en", pht_rd_en, 1);
      chk("vec_rd_idx", pht_rd_idx, vt[i].idx);
      tick;
      chk("vec_we", pht_we, 1);
      chk("vec_widx", pht_widx, vt[i].idx);
      chk("vec_wdata", pht_wdata, vt[i].w);
      tick;
      chk("vec_we_after", pht_we, 0);
      pht_m[vt[i].idx] = vt[i].w;
    end

    ex_valid = 1; ex_pc = 32'h44; ex_taken = 0; ex_next_pc = 32'h100; ex_pdt_pc = 32'h44;
    tick;
    ex_valid = 0;
    chk("misp_flush", flush, 1);
    chk("misp_redirect", redirect_pc, 32'h100);
    chk("misp_ghr", ghr, 12'h064);
    tick;
    chk("misp_flush_pulse", flush, 0);
    chk("misp_rd_idx", pht_rd_idx, 12'h023);
    tick;
    chk("misp_we", pht_we, 1);
    chk("misp_widx", pht_widx, 12'h023);
    chk("misp_wdata", pht_wdata, 0);
    tick;
    ghr_m = 12'h064;
    fifo_n = 0; eng = 0; exp_flush = 0; exp_redir = 0;

    run_model(8, 1);
    run_model(30, 2);
    run_model(400, 0);
    run_model(40, 2);

    for (int k = 0; k < 5; k++) begin
      ex_valid = 1; ex_pc = 32'h100 + 32'(k * 4); ex_taken = 1; ex_next_pc = 0; ex_pdt_pc = 0;
      tick;
    end
    ex_valid = 0;
    tick;
    chk("mid_write_state", pht_we, 1);
    rst = 1;
    #1;
    chk("mid_rst_we", pht_we, 0);
    chk("mid_rst_stall", stallreq, 1);
    tick;
    rst = 0;
    #1;
    chk("mid_restart_ghr", ghr, 0);
    chk("mid_restart_busy", init_busy, 1);
    check_sweep("sweep2");
    wcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (pht_we) wcnt++;
      tick;
    end
    chk("no_stale_write", wcnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
